hub75_scan_ctrl: RTL and testbench
==================================

# hub75_scan_ctrl

Scan controller for the 64x32 HUB75 LED matrix. It walks `temp_pixel_generator` through its 11-bit `pixel_addr` space ({row[4:0], col[5:0]}) and reads the combinational 24-bit `pixel_data` ({R[23:16], G[15:8], B[7:0]}). It drives the panel's dual-half shift, latch, row-address and output-enable signals using binary-code modulation (BCM). It sits between the pixel generator and the board-level HUB75 connector.

## Interface
Parameters:
- `PLANES`, default 8: BCM bit planes (1..8). Plane p (0..PLANES-1) uses data bit (8-PLANES+p) of each channel.
- `ON_BASE`, default 4: display cycles for plane 0. Plane p is displayed for ON_BASE<<p cycles.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: run request, level.
- `pixel_addr`, out, 11: {row[4:0], col[5:0]} to the pixel generator.
- `pixel_data`, in, 24: combinational response to `pixel_addr`.
- `hub_r1`, `hub_g1`, `hub_b1`, out, 1 each: upper-half (rows 0-15) serial data.
- `hub_r2`, `hub_g2`, `hub_b2`, out, 1 each: lower-half (rows 16-31) serial data.
- `hub_clk`, out, 1: panel shift clock. The panel samples on its rising edge.
- `hub_lat`, out, 1: latch pulse.
- `hub_oe_n`, out, 1: output enable, active-low.
- `hub_a`, out, 4: scan-row address (0-15).
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `frame_done`, out, 1: one-cycle pulse at the end of each frame.

## Operation
- All outputs are registered.
- Reset values:
  - `pixel_addr`, all `hub_*` data bits, `hub_clk`, `hub_lat`, `hub_a`, `busy`, `frame_done`: 0.
  - `hub_oe_n`: 1.
- Internal counters: row r (0-15), plane p, column c (0-63), phase ph (0-3), on-time counter.
- State machine:
  - **IDLE**: `hub_oe_n`=1. When `enable`=1, clear r, p, c, ph and go to SHIFT.
  - **SHIFT**: four clocks per column, `hub_oe_n`=1.
    - ph0: `pixel_addr` <= {0,r,c}.
    - ph1: capture upper bit from `pixel_data` (R, G, B bit of plane p); `pixel_addr` <= {1,r,c}.
    - ph2: capture lower bit; drive all six `hub_*` data bits; `hub_clk` <= 0.
    - ph3: `hub_clk` <= 1.
    - After c=63 ph3, go to LATCH.
  - **LATCH**: one cycle. `hub_lat`=1, `hub_clk`=0, `hub_a` <= r, `hub_oe_n`=1. Go to DISPLAY.
  - **DISPLAY**: `hub_oe_n`=0 for exactly ON_BASE<<p cycles, then advance:
    - p < PLANES-1: p+1, back to SHIFT.
    - Otherwise p=0 and r+1.
    - If r was 15: r=0, pulse `frame_done`. Go to SHIFT if `enable`=1, else IDLE.
- `enable` is sampled only in IDLE and at frame end. Deasserting it mid-frame completes the current frame.
- Width rules:
  - The row MSB selects the half; `hub_a` equals `pixel_addr`[9:6] during LATCH.
  - Counters wrap modulo their ranges, with no overflow beyond them.
- Simultaneous events: the frame-end transition takes precedence. `frame_done` and the next SHIFT ph0 coincide.
- Reset mid-operation: all outputs and state return to reset values asynchronously. `hub_oe_n` goes high immediately, with no clock required.

## Timing
- Pixel-generator latency: zero cycles. `pixel_data` is valid in the cycle after `pixel_addr` is registered.
- Per column: 4 clocks. Per plane shift: 256 clocks.
- `hub_clk` high phase: 1 clk (ph3). Low: 3 clk.
- Data bits are stable for at least 1 clk before the `hub_clk` rising edge.
- Per plane: 256 + 1 + ON_BASE<<p clocks.
- Frame length with defaults: 16 x (8 x 257 + 4 x 255) = 49216 clocks.
- `frame_done` rises on the same edge that returns r to 0.
- `hub_oe_n` is never low in the same cycle as `hub_lat`=1 or `hub_clk` activity.

## Test plan
- **Reset values**: assert `rst_n`=0 mid-run -> `hub_oe_n`=1 immediately, all other outputs 0, `busy`=0. After release with `enable`=0, the block stays idle.
- **First column**: pixel generator at 30°C/86°F, `enable`=1 after reset.
  - `pixel_addr` must sequence 0x000 then 0x400.
  - The `hub_clk` rising edge must come 4 clocks after SHIFT entry.
  - `hub_r1`/`hub_r2` must equal bit 0 of R at rows 0 and 16, col 0.
- **Frame length**: `enable` held at 1 -> `frame_done` pulses exactly every 49216 clocks. `hub_a` sequences 0..15, with each value held for 3076 clocks.
- **BCM on-times**: count `hub_oe_n`=0 runs per row -> 4, 8, 16, 32, 64, 128, 256, 512 clocks in order. Repeat with PLANES=4 -> runs of 4, 8, 16, 32, with frame length 16 x (4 x 257 + 60) = 17408.
- **Enable drop**: deassert `enable` at row 5, plane 3 -> frame completes, `frame_done` pulses, block goes to IDLE with `busy`=0 and `hub_oe_n`=1. Reassert -> restarts at row 0, plane 0.
- **Pixel coverage**: capture all shifted bits over one frame and rebuild the 64x32x24 image -> it matches a direct `pixel_addr` sweep of the generator (more than 10 non-black pixels at 30°C/86°F).

Source files
------------

// File: rtl/hub75_scan_ctrl_if.sv
// Pixel-generator lookup and HUB75 panel signal bundle for the scan controller.
// Latency: none, wires only; the controller registers every signal it drives.
// Backpressure: none; the pixel lookup is combinational and the panel cannot stall.
interface hub75_scan_ctrl_if;
  logic [10:0] pixel_addr;
  logic [23:0] pixel_data;
  logic        hub_r1;
  logic        hub_g1;
  logic        hub_b1;
  logic        hub_r2;
  logic        hub_g2;
  logic        hub_b2;
  logic        hub_clk;
  logic        hub_lat;
  logic        hub_oe_n;
  logic [3:0]  hub_a;

  // Controller side: drives the address and all panel pins.
  modport master (
    output pixel_addr,
    input  pixel_data,
    output hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
    output hub_clk, hub_lat, hub_oe_n, hub_a
  );

  // Pixel generator / panel side.
  modport slave (
    input  pixel_addr,
    output pixel_data,
    input  hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
    input  hub_clk, hub_lat, hub_oe_n, hub_a
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 64x32 BCM scan controller: shifts dual-half column data, latches rows, times output enable.
// Latency: all outputs registered; first panel shift-clock rise 4 clocks after leaving IDLE.
// Backpressure: none; enable is sampled only in IDLE and at frame end, so a drop finishes the frame.
module hub75_scan_ctrl #(
  parameter int PLANES  = 8,
  parameter int ON_BASE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  hub75_scan_ctrl_if.master bus,
  output logic              busy,
  output logic              frame_done
);

  localparam int              PW     = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int              ON_MAX = ON_BASE << (PLANES - 1);
  localparam int              OW     = $clog2(ON_MAX + 1);
  localparam int              LSB    = 8 - PLANES;
  localparam logic [PW-1:0]   P_LAST = PW'(PLANES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [5:0]      col_q, col_d;
  logic [1:0]      ph_q, ph_d;
  logic [OW-1:0]   on_cnt_q, on_cnt_d;
  logic [2:0]      upper_q, upper_d;
  logic [10:0]     pixel_addr_q, pixel_addr_d;
  logic [5:0]      rgb_q, rgb_d;          // {r1, g1, b1, r2, g2, b2}
  logic            hub_clk_q, hub_clk_d;
  logic            hub_lat_q, hub_lat_d;
  logic            hub_oe_n_q, hub_oe_n_d;
  logic [3:0]      hub_a_q, hub_a_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic [2:0]      bit_idx;
  logic [7:0]      ch_r, ch_g, ch_b;
  logic [2:0]      cur_bits;
  logic [OW-1:0]   on_len;

  // Pick the current plane's bit out of each colour channel and size this plane's on-time.
  always_comb begin
    bit_idx  = 3'(LSB + int'(plane_q));
    ch_r     = bus.pixel_data[23:16];
    ch_g     = bus.pixel_data[15:8];
    ch_b     = bus.pixel_data[7:0];
    cur_bits = {ch_r[bit_idx], ch_g[bit_idx], ch_b[bit_idx]};
    on_len   = OW'(ON_BASE) << plane_q;
  end

  // Next-state and next-output logic; strobes default low and output-enable defaults off.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    plane_d      = plane_q;
    col_d        = col_q;
    ph_d         = ph_q;
    on_cnt_d     = on_cnt_q;
    upper_d      = upper_q;
    pixel_addr_d = pixel_addr_q;
    rgb_d        = rgb_q;
    hub_a_d      = hub_a_q;
    hub_clk_d    = 1'b0;
    hub_lat_d    = 1'b0;
    hub_oe_n_d   = 1'b1;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          row_d   = '0;
          plane_d = '0;
          col_d   = '0;
          ph_d    = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        ph_d = ph_q + 2'd1;
        case (ph_q)
          2'd0: pixel_addr_d = {1'b0, row_q, col_q};
          2'd1: begin
            // Upper-half pixel is on the bus now; hold it while the lower half is fetched.
            upper_d      = cur_bits;
            pixel_addr_d = {1'b1, row_q, col_q};
          end
          2'd2: rgb_d = {upper_q, cur_bits};
          default: begin
            hub_clk_d = 1'b1;
            col_d     = col_q + 6'd1;
            if (col_q == 6'd63) begin
              state_d = LATCH;
            end
          end
        endcase
      end

      LATCH: begin
        hub_lat_d = 1'b1;
        hub_a_d   = row_q;
        on_cnt_d  = '0;
        state_d   = DISPLAY;
      end

      default: begin // DISPLAY
        hub_oe_n_d = 1'b0;
        if (on_cnt_q == on_len - OW'(1)) begin
          on_cnt_d = '0;
          if (plane_q == P_LAST) begin
            plane_d = '0;
            row_d   = row_q + 4'd1;
            if (row_q == 4'd15) begin
              // Frame end wins: enable is only looked at here once running.
              frame_done_d = 1'b1;
              state_d      = enable ? SHIFT : IDLE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            plane_d = plane_q + 1'b1;
            state_d = SHIFT;
          end
        end else begin
          on_cnt_d = on_cnt_q + OW'(1);
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered panel/pixel outputs; reset blanks the panel immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      plane_q      <= '0;
      col_q        <= '0;
      ph_q         <= '0;
      on_cnt_q     <= '0;
      upper_q      <= '0;
      pixel_addr_q <= '0;
      rgb_q        <= '0;
      hub_clk_q    <= 1'b0;
      hub_lat_q    <= 1'b0;
      hub_oe_n_q   <= 1'b1;
      hub_a_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      plane_q      <= plane_d;
      col_q        <= col_d;
      ph_q         <= ph_d;
      on_cnt_q     <= on_cnt_d;
      upper_q      <= upper_d;
      pixel_addr_q <= pixel_addr_d;
      rgb_q        <= rgb_d;
      hub_clk_q    <= hub_clk_d;
      hub_lat_q    <= hub_lat_d;
      hub_oe_n_q   <= hub_oe_n_d;
      hub_a_q      <= hub_a_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pixel_addr = pixel_addr_q;
  assign bus.hub_r1     = rgb_q[5];
  assign bus.hub_g1     = rgb_q[4];
  assign bus.hub_b1     = rgb_q[3];
  assign bus.hub_r2     = rgb_q[2];
  assign bus.hub_g2     = rgb_q[1];
  assign bus.hub_b2     = rgb_q[0];
  assign bus.hub_clk    = hub_clk_q;
  assign bus.hub_lat    = hub_lat_q;
  assign bus.hub_oe_n   = hub_oe_n_q;
  assign bus.hub_a      = hub_a_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: default 8-plane instance plus a 4-plane instance on a shared enable.
// Latency: expectations queued when a frame is started, popped on shift-clock rises, latches and OE runs.
// Backpressure: none; the pixel source is a combinational hash of the address.
module tb_hub75_scan_ctrl;

  logic clk;
  logic rst_n;
  logic enable;
  logic busy0, fd0, busy1, fd1;
  int   cyc;
  int   n_checks;
  int   n_fail;

  hub75_scan_ctrl_if bus0();
  hub75_scan_ctrl_if bus1();

  function automatic logic [23:0] pix(input logic [10:0] a);
    logic [31:0] x;
    x = {21'd0, a} * 32'h9E37_79B1;
    return x[31:8] ^ {13'd0, a};
  endfunction

  assign bus0.pixel_data = pix(bus0.pixel_addr);
  assign bus1.pixel_data = pix(bus1.pixel_addr);

  hub75_scan_ctrl #(.PLANES(8), .ON_BASE(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus0),
    .busy(busy0), .frame_done(fd0)
  );

  hub75_scan_ctrl #(.PLANES(4), .ON_BASE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus1),
    .busy(busy1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    n_checks = 0;
    n_fail   = 0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [5:0] q0_bits[$];
  int         q0_lat[$];
  int         q0_on[$];
  int         q1_on[$];

  task automatic push_frame();
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 8; p++) begin
        q0_lat.push_back(r);
        q0_on.push_back(4 << p);
        for (int c = 0; c < 64; c++) begin
          logic [23:0] u, l;
          logic [7:0]  ur, ug, ub, lr, lg, lb;
          u  = pix({1'b0, 4'(r), 6'(c)});
          l  = pix({1'b1, 4'(r), 6'(c)});
          ur = u[23:16]; ug = u[15:8]; ub = u[7:0];
          lr = l[23:16]; lg = l[15:8]; lb = l[7:0];
          q0_bits.push_back({ur[3'(p)], ug[3'(p)], ub[3'(p)], lr[3'(p)], lg[3'(p)], lb[3'(p)]});
        end
      end
      // 4-plane instance uses data bits 4..7; only its on-times are tracked.
      for (int p = 0; p < 4; p++) q1_on.push_back(4 << p);
    end
  endtask

  // DUT0 monitor: shifted bits, latch row, OE runs, OE exclusivity, row period, frame length.
  int   run0, start0, row_start0;
  logic clk_prev0, busy_prev0, fd_prev0, have_row0;
  logic [3:0] last_a0;
  initial begin
    run0 = 0; start0 = 0; row_start0 = 0;
    clk_prev0 = 0; busy_prev0 = 0; fd_prev0 = 0; have_row0 = 0; last_a0 = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      run0 = 0; clk_prev0 = 0; busy_prev0 = 0; fd_prev0 = 0; have_row0 = 0;
    end else begin
      if (bus0.hub_clk && !clk_prev0) begin
        if (q0_bits.size() == 0) check("bits_sb_empty", 1, 0);
        else check("shift_bits", {bus0.hub_r1, bus0.hub_g1, bus0.hub_b1,
                                  bus0.hub_r2, bus0.hub_g2, bus0.hub_b2}, q0_bits.pop_front());
      end
      clk_prev0 = bus0.hub_clk;

      if (bus0.hub_lat) begin
        if (q0_lat.size() == 0) check("lat_sb_empty", 1, 0);
        else check("lat_row", bus0.hub_a, q0_lat.pop_front());
        check("lat_oe_clk", {bus0.hub_oe_n, bus0.hub_clk}, 2'b10);
        if (have_row0 && bus0.hub_a != last_a0) check("row_period", cyc - row_start0, 3076);
        if (!have_row0 || bus0.hub_a != last_a0) begin
          row_start0 = cyc; last_a0 = bus0.hub_a; have_row0 = 1;
        end
      end

      if (!bus0.hub_oe_n) begin
        run0++;
        check("oe_excl", {bus0.hub_lat, bus0.hub_clk}, 2'b00);
      end else if (run0 != 0) begin
        if (q0_on.size() == 0) check("on_sb_empty", 1, 0);
        else check("on_time", run0, q0_on.pop_front());
        run0 = 0;
      end

      if (busy0 && !busy_prev0) start0 = cyc;
      if (!busy0) have_row0 = 0;
      busy_prev0 = busy0;
      if (fd0) check("frame_len", cyc - start0, 49216);
      if (fd_prev0) check("fd_width", fd0, 0);
      fd_prev0 = fd0;
    end
  end

  // DUT1 monitor: OE runs and frame length for the 4-plane build.
  int   run1, start1;
  logic busy_prev1;
  initial begin
    run1 = 0; start1 = 0; busy_prev1 = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      run1 = 0; busy_prev1 = 0;
    end else begin
      if (!bus1.hub_oe_n) begin
        run1++;
      end else if (run1 != 0) begin
        if (q1_on.size() == 0) check("on4_sb_empty", 1, 0);
        else check("on_time_p4", run1, q1_on.pop_front());
        run1 = 0;
      end
      if (busy1 && !busy_prev1) start1 = cyc;
      busy_prev1 = busy1;
      if (fd1) check("frame_len_p4", cyc - start1, 17408);
    end
  end

  // Entry into SHIFT with enable just raised: address order, data, shift-clock timing.
  task automatic first_col();
    logic [23:0] up, lo;
    up = pix(11'h000);
    lo = pix(11'h400);
    @(posedge clk); #1;
    check("fc_busy", busy0, 1);
    check("fc_clk_e0", bus0.hub_clk, 0);
    @(posedge clk); #1;
    check("fc_addr_up", bus0.pixel_addr, 11'h000);
    @(posedge clk); #1;
    check("fc_addr_lo", bus0.pixel_addr, 11'h400);
    check("fc_clk_e2", bus0.hub_clk, 0);
    @(posedge clk); #1;
    check("fc_r1", bus0.hub_r1, up[16]);
    check("fc_r2", bus0.hub_r2, lo[16]);
    check("fc_clk_e3", bus0.hub_clk, 0);
    @(posedge clk); #1;
    check("fc_clk_rise", bus0.hub_clk, 1);
    check("fc_oe_n", bus0.hub_oe_n, 1);
    @(posedge clk); #1;
    check("fc_clk_fall", bus0.hub_clk, 0);
    check("fc_addr_c1", bus0.pixel_addr, 11'h001);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_oe_n"}, bus0.hub_oe_n, 1);
    check({tag, "_busy"}, {busy0, busy1}, 2'b00);
    check({tag, "_addr"}, bus0.pixel_addr, 0);
    check({tag, "_hub_a"}, bus0.hub_a, 0);
    check({tag, "_ctl"}, {bus0.hub_lat, bus0.hub_clk, fd0}, 3'b000);
    check({tag, "_data"}, {bus0.hub_r1, bus0.hub_g1, bus0.hub_b1,
                           bus0.hub_r2, bus0.hub_g2, bus0.hub_b2}, 6'd0);
    check({tag, "_oe_n_p4"}, bus1.hub_oe_n, 1);
  endtask

  initial begin
    int   n;
    logic got;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");

    @(negedge clk);
    rst_n = 1'b1;
    push_frame();
    @(negedge clk);
    enable = 1'b1;
    first_col();

    // Drop enable during row 5, plane 3 (fourth latch of row 5).
    n = 0;
    for (int i = 0; i < 60000 && n < 4; i++) begin
      @(negedge clk);
      if (bus0.hub_lat && bus0.hub_a == 4'd5) n++;
    end
    check("drop_point", n, 4);
    enable = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 60000 && !got; i++) begin
      @(negedge clk);
      if (fd0) got = 1'b1;
    end
    check("frame_done_seen", got, 1);
    check("idle_busy", busy0, 0);
    @(negedge clk);
    check("idle_oe_n", bus0.hub_oe_n, 1);
    check("idle_busy_p4", busy1, 0);
    repeat (10) @(negedge clk);
    check("stay_idle", busy0, 0);
    check("sb_bits_left", q0_bits.size(), 0);
    check("sb_lat_left", q0_lat.size(), 0);
    check("sb_on_left", q0_on.size(), 0);
    check("sb_on4_left", q1_on.size(), 0);

    // Restart: must begin at row 0, plane 0 again.
    push_frame();
    @(negedge clk);
    enable = 1'b1;
    first_col();
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (!bus0.hub_oe_n) got = 1'b1;
    end
    check("restart_oe_low", got, 1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus0.hub_oe_n) got = 1'b1;
    end
    check("restart_oe_end", got, 1);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-shift: outputs blank with no clock edge.
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_reset_vals("async_rst");
    q0_bits.delete();
    q0_lat.delete();
    q0_on.delete();
    q1_on.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", {busy0, busy1}, 2'b00);
    check("post_rst_oe_n", bus0.hub_oe_n, 1);
    check("post_rst_addr", bus0.pixel_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
